// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, mcycle/minstret counters and ecall/mret trap sequencer.
// Latency: csr_rdata/csr_illegal are combinational; the redirect is registered, one cycle after the retiring edge.
// Backpressure: busy is held for the single REDIRECT cycle, and retires offered during it are ignored.
module csr_trap_unit #(
  parameter int unsigned XLEN          = 32,
  parameter logic [63:0] MSTATUS_RESET = 64'h1800,
  parameter logic [63:0] MTVEC_RESET   = 64'h0,
  parameter int unsigned ECALL_CAUSE   = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            retire,
  input  logic [XLEN-1:0] pc,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            ecall,
  input  logic            mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam bit IS32 = (XLEN == 32);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // MPP is hardwired to M-mode on read; only MIE, MPIE and MPP bits are stored from writes.
  localparam logic [XLEN-1:0] MPP_BITS   = XLEN'(64'h1800);
  localparam logic [XLEN-1:0] MS_WMASK   = XLEN'(64'h1888);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(64'h3);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [63:0]     mcycle_q;
  logic [63:0]     minstret_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] rd_val;
  logic            mapped;
  logic [XLEN-1:0] wval;
  logic            op_writes;
  logic            csr_wr;
  logic            active;
  logic            ecall_take;
  logic            mret_take;
  logic            ret_wr;
  logic [63:0]     cyc_nxt;
  logic [63:0]     ret_nxt;

  // Read mux; also serves as the "old value" for set/clear writes.
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (csr_addr)
      A_MSTATUS:  rd_val = mstatus_q | MPP_BITS;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MCYCLE:   rd_val = mcycle_q[XLEN-1:0];
      A_MINSTRET: rd_val = minstret_q[XLEN-1:0];
      A_MCYCLEH: begin
        if (IS32) rd_val = XLEN'(mcycle_q[63:32]);
        else      mapped = 1'b0;
      end
      A_MINSTRETH: begin
        if (IS32) rd_val = XLEN'(minstret_q[63:32]);
        else      mapped = 1'b0;
      end
      default: mapped = 1'b0;
    endcase
  end

  assign csr_rdata   = rd_val;
  assign csr_illegal = csr_en && !mapped;

  always_comb begin
    wval      = rd_val;
    op_writes = 1'b0;
    case (csr_op)
      OP_RW: begin
        wval      = csr_wdata;
        op_writes = 1'b1;
      end
      OP_RS: begin
        wval      = rd_val | csr_wdata;
        op_writes = (csr_wdata != '0);
      end
      OP_RC: begin
        wval      = rd_val & ~csr_wdata;
        op_writes = (csr_wdata != '0);
      end
      default: begin
        wval      = rd_val;
        op_writes = 1'b0;
      end
    endcase
  end

  // FSM next state and trap decode; ecall has priority over mret.
  always_comb begin
    state_d        = state_q;
    ecall_take     = 1'b0;
    mret_take      = 1'b0;
    busy           = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (retire && ecall) begin
          ecall_take = 1'b1;
          state_d    = REDIRECT;
        end else if (retire && mret) begin
          mret_take = 1'b1;
          state_d   = REDIRECT;
        end
      end
      REDIRECT: begin
        busy           = 1'b1;
        redirect_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign active = retire && !busy;
  assign csr_wr = active && csr_en && mapped && op_writes && !ecall_take && !mret_take;
  assign ret_wr = csr_wr && ((csr_addr == A_MINSTRET) || (csr_addr == A_MINSTRETH));

  // Counter next values: increment first, then a CSR write replaces only the written half.
  always_comb begin
    cyc_nxt = mcycle_q + 64'd1;
    if (csr_wr && (csr_addr == A_MCYCLE))
      cyc_nxt[XLEN-1:0] = wval;
    if (IS32 && csr_wr && (csr_addr == A_MCYCLEH))
      cyc_nxt[63:32] = wval[31:0];

    ret_nxt = minstret_q + {63'd0, (active && !ret_wr)};
    if (csr_wr && (csr_addr == A_MINSTRET))
      ret_nxt[XLEN-1:0] = wval;
    if (IS32 && csr_wr && (csr_addr == A_MINSTRETH))
      ret_nxt[63:32] = wval[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (ecall_take)
        redirect_pc_q <= mtvec_q;
      else if (mret_take)
        redirect_pc_q <= mepc_q;
    end
  end

  assign redirect_pc = redirect_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RESET[XLEN-1:0];
      mtvec_q    <= MTVEC_RESET[XLEN-1:0];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (ecall_take) begin
      mepc_q       <= pc & ALIGN_MASK;
      mcause_q     <= XLEN'(ECALL_CAUSE);
      mstatus_q[7] <= mstatus_q[3];
      mstatus_q[3] <= 1'b0;
    end else if (mret_take) begin
      mstatus_q[3] <= mstatus_q[7];
      mstatus_q[7] <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        A_MSTATUS:  mstatus_q  <= (mstatus_q & ~MS_WMASK) | (wval & MS_WMASK);
        A_MTVEC:    mtvec_q    <= wval & ALIGN_MASK;
        A_MSCRATCH: mscratch_q <= wval;
        A_MEPC:     mepc_q     <= wval & ALIGN_MASK;
        A_MCAUSE:   mcause_q   <= wval;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= cyc_nxt;
      minstret_q <= ret_nxt;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit (XLEN=32): vector table for CSR access, hand sequences for traps, counters and reset.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = '0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        ecall = 1'b0;
  logic        mret = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  csr_trap_unit #(
    .XLEN(32),
    .MSTATUS_RESET(64'h1800),
    .MTVEC_RESET(64'h0),
    .ECALL_CAUSE(11)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .retire(retire),
    .pc(pc),
    .csr_en(csr_en),
    .csr_op(csr_op),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal),
    .ecall(ecall),
    .mret(mret),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        retire;
    logic        en;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic ec, input logic mr, input logic [31:0] p);
    @(negedge clk);
    retire    = r;
    csr_en    = en;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    ecall     = ec;
    mret      = mr;
    pc        = p;
  endtask

  task automatic rd(input logic [11:0] addr, input string name, input logic [31:0] exp);
    drive(1'b0, 1'b0, 2'b00, addr, 32'h0, 1'b0, 1'b0, 32'h0);
    sb_push(name, exp);
    #1 sb_pop(csr_rdata);
  endtask

  initial begin
    // {retire, csr_en, op, addr, wdata, expected old rdata, expected illegal}
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h300, 32'h0,        32'h0000_1800, 1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h305, 32'h0,        32'h0,         1'b0});
    vt.push_back('{1'b0, 1'b1, 2'b00, 12'h7C0, 32'h0,        32'h0,         1'b1});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h7C0, 32'h0,        32'h0,         1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b01, 12'h305, 32'h8000_0103, 32'h0,        1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h305, 32'h0,        32'h8000_0100, 1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b10, 12'h340, 32'h4,        32'h0,         1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h340, 32'h0,        32'h4,         1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b11, 12'h340, 32'h4,        32'h4,         1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h340, 32'h0,        32'h0,         1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b01, 12'h7C0, 32'hFFFF,     32'h0,         1'b1});
    vt.push_back('{1'b0, 1'b1, 2'b00, 12'h7C0, 32'h0,        32'h0,         1'b1});
    vt.push_back('{1'b1, 1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h300, 32'h0,        32'h0000_1888, 1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b11, 12'h300, 32'h0000_1888, 32'h0000_1888, 1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h300, 32'h0,        32'h0000_1800, 1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b01, 12'h341, 32'h0000_0123, 32'h0,        1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h341, 32'h0,        32'h0000_0120, 1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b10, 12'h341, 32'h0,        32'h0000_0120, 1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h341, 32'h0,        32'h0000_0120, 1'b0});
    vt.push_back('{1'b1, 1'b1, 2'b00, 12'h340, 32'hFF,       32'h0,         1'b0});
    vt.push_back('{1'b0, 1'b0, 2'b00, 12'h340, 32'h0,        32'h0,         1'b0});

    // Reset state of registered outputs.
    #1;
    sb_push("rst_redirect_valid", 32'h0);
    sb_push("rst_busy", 32'h0);
    sb_push("rst_redirect_pc", 32'h0);
    sb_pop({31'b0, redirect_valid});
    sb_pop({31'b0, busy});
    sb_pop(redirect_pc);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].retire, vt[i].en, vt[i].op, vt[i].addr, vt[i].wd, 1'b0, 1'b0, 32'h0);
      sb_push($sformatf("vec%0d_rdata", i), vt[i].exp_rd);
      sb_push($sformatf("vec%0d_illegal", i), {31'b0, vt[i].exp_ill});
      #1;
      sb_pop(csr_rdata);
      sb_pop({31'b0, csr_illegal});
    end

    // ecall with MIE=1, mtvec=0x8000_0100.
    drive(1'b1, 1'b1, 2'b10, 12'h300, 32'h8, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 12'h000, 32'h0, 1'b1, 1'b0, 32'h8000_0040);
    sb_push("ecall_busy_before", 32'h0);
    #1 sb_pop({31'b0, busy});
    sb_push("ecall_redirect_valid", 32'h1);
    sb_push("ecall_redirect_pc", 32'h8000_0100);
    sb_push("ecall_busy", 32'h1);
    // A retire offered during REDIRECT must be ignored.
    drive(1'b1, 1'b1, 2'b01, 12'h340, 32'hDEAD, 1'b0, 1'b0, 32'h0);
    #1;
    sb_pop({31'b0, redirect_valid});
    sb_pop(redirect_pc);
    sb_pop({31'b0, busy});
    drive(1'b0, 1'b0, 2'b00, 12'h340, 32'h0, 1'b0, 1'b0, 32'h0);
    sb_push("ecall_valid_drop", 32'h0);
    sb_push("ecall_busy_drop", 32'h0);
    sb_push("redirect_ignores_csr", 32'h0);
    #1;
    sb_pop({31'b0, redirect_valid});
    sb_pop({31'b0, busy});
    sb_pop(csr_rdata);
    rd(12'h341, "ecall_mepc", 32'h8000_0040);
    rd(12'h342, "ecall_mcause", 32'd11);
    rd(12'h300, "ecall_mstatus", 32'h0000_1880);

    // mret back to the trapping pc.
    drive(1'b1, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 1'b1, 32'h0);
    sb_push("mret_redirect_valid", 32'h1);
    sb_push("mret_redirect_pc", 32'h8000_0040);
    drive(1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    sb_pop({31'b0, redirect_valid});
    sb_pop(redirect_pc);
    rd(12'h300, "mret_mstatus", 32'h0000_1888);

    // ecall + mret + CSR write together: ecall path only, write dropped.
    drive(1'b1, 1'b1, 2'b01, 12'h340, 32'h55, 1'b1, 1'b1, 32'h8000_0080);
    sb_push("both_redirect_pc", 32'h8000_0100);
    drive(1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 sb_pop(redirect_pc);
    rd(12'h341, "both_mepc", 32'h8000_0080);
    rd(12'h300, "both_mstatus", 32'h0000_1880);
    rd(12'h340, "both_csr_dropped", 32'h0);

    // mcycle low-half rollover carries into mcycleh.
    drive(1'b1, 1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    rd(12'hB00, "mcycle_written", 32'hFFFF_FFFF);
    rd(12'hB00, "mcycle_wrap_lo", 32'h0);
    csr_addr = 12'hB80;
    sb_push("mcycle_wrap_hi", 32'h1);
    #1 sb_pop(csr_rdata);

    // minstret write wins over the retiring increment.
    drive(1'b1, 1'b1, 2'b01, 12'hB02, 32'd5, 1'b0, 1'b0, 32'h0);
    rd(12'hB02, "minstret_written", 32'd5);
    drive(1'b1, 1'b1, 2'b00, 12'hB02, 32'h0, 1'b0, 1'b0, 32'h0);
    sb_push("minstret_old", 32'd5);
    #1 sb_pop(csr_rdata);
    rd(12'hB02, "minstret_incr", 32'd6);
    rd(12'hB82, "minstreth", 32'h0);

    // Asynchronous reset in the middle of REDIRECT.
    drive(1'b1, 1'b0, 2'b00, 12'h000, 32'h0, 1'b1, 1'b0, 32'h8000_0200);
    sb_push("pre_rst_valid", 32'h1);
    sb_push("pre_rst_busy", 32'h1);
    drive(1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    sb_pop({31'b0, redirect_valid});
    sb_pop({31'b0, busy});
    #1 rst_n = 1'b0;
    sb_push("async_rst_valid", 32'h0);
    sb_push("async_rst_busy", 32'h0);
    sb_push("async_rst_pc", 32'h0);
    #1;
    sb_pop({31'b0, redirect_valid});
    sb_pop({31'b0, busy});
    sb_pop(redirect_pc);
    @(negedge clk);
    rst_n = 1'b1;
    csr_addr = 12'hB00;
    sb_push("post_rst_mcycle", 32'h0);
    #1 sb_pop(csr_rdata);
    csr_addr = 12'hB02;
    sb_push("post_rst_minstret", 32'h0);
    #1 sb_pop(csr_rdata);
    csr_addr = 12'h300;
    sb_push("post_rst_mstatus", 32'h0000_1800);
    #1 sb_pop(csr_rdata);
    csr_addr = 12'h341;
    sb_push("post_rst_mepc", 32'h0);
    #1 sb_pop(csr_rdata);

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
